toggle_event_responder: RTL and testbench
=========================================

// Module: toggle_event_responder
// PURPOSE
//  Receiving end of the toggle-encoded event link driven by a T master-slave flip-flop
//  in another clock domain. Each level change on t_in is one event.
//  - Synchronises t_in and detects every toggle.
//  - Buffers up to DEPTH outstanding events for a local consumer (valid/ready).
//  - Returns one toggle on ack_t per consumed event, closing the toggle handshake.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on t_in; legal range 0..3; 0 = t_in already in clk domain
//  DEPTH        4  max outstanding (detected, unconsumed) events; legal range 1..15
//  CNT_W        8  width of the free-running detected-toggle counter
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous, active-low reset
//  t_in       in   1                  toggle-encoded event line from the remote T flip-flop
//  evt_ready  in   1                  consumer accepts one event this cycle
//  clr_ovf    in   1                  synchronous clear of the sticky overflow flag
//  pulse_out  out  1                  one-cycle pulse per detected toggle, including dropped ones
//  evt_valid  out  1                  high while pending != 0
//  pending    out  $clog2(DEPTH+1)    outstanding event count
//  ack_t      out  1                  toggles once per accepted event
//  evt_count  out  CNT_W              total detected toggles, wraps modulo 2^CNT_W
//  overflow   out  1                  sticky: a toggle was dropped because the buffer was full
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, any time, including mid-operation):
//   - Sync flops, t_prev, pulse_out, pending, evt_valid, ack_t, evt_count and overflow go to 0.
//   - FSM goes to INIT.
//  Synchroniser: t_sync = last sync stage (t_in directly when SYNC_STAGES=0).
//  Toggle detection:
//   - t_prev <= t_sync every cycle.
//   - det = (t_sync ^ t_prev) and state != INIT.
//  Latency:
//   - A t_in change settled before rising edge n gives pulse_out = 1 after edge n+SYNC_STAGES, for exactly 1 cycle.
//   - evt_valid and pending update on that same edge.
//  FSM states: INIT, IDLE (pending=0), BUSY (0<pending<DEPTH), FULL (pending=DEPTH).
//   - INIT: lasts SYNC_STAGES+1 cycles after reset release. t_prev tracks t_sync. No det.
//     This suppresses a false event when t_in=1 at reset release. Then go to IDLE.
//   - IDLE/BUSY/FULL: chosen from the next value of pending on every edge.
//  accept = evt_valid & evt_ready. evt_ready is ignored when evt_valid=0.
//  pending update:
//   - det & !accept   -> +1, unless FULL, in which case drop the toggle and set overflow.
//   - !det & accept   -> -1.
//   - det & accept    -> unchanged. In FULL the toggle is not dropped and overflow is not set.
//  ack_t: inverts on the edge where accept=1. At most one toggle per cycle.
//  evt_count: +1 on every det, including dropped ones. Wraps from 2^CNT_W-1 to 0.
//  overflow: set on a drop; cleared by clr_ovf. A set and a clear in the same cycle -> set wins.
//  Toggle rate: the source must hold each t_in level for at least 2 clk cycles.
//   Faster toggling is outside the contract: events may be lost and no flag is raised.
//  All outputs are registered. No combinational path from input to output.
// TESTING
//  T1: rst_n=0 with t_in=1, release, wait 5 cycles
//      -> no pulse_out, pending=0, evt_count=0, state leaves INIT after 3 cycles.
//  T2: SYNC_STAGES=2, t_in 0->1 before edge n, evt_ready=0
//      -> pulse_out high after edge n+2 only, pending=1, evt_valid=1, evt_count=1.
//  T3: 3 toggles spaced 4 cycles apart, then evt_ready=1 for 3 cycles
//      -> pending 1,2,3 then 2,1,0, ack_t toggles 3 times (ends at 1), evt_valid falls with pending=0.
//  T4: 5 toggles with DEPTH=4 and evt_ready=0
//      -> pending=4 (FULL), overflow=1, evt_count=5, 5 pulses.
//      Then pulse clr_ovf -> overflow=0.
//  T5: in FULL, a toggle is detected in the same cycle as evt_ready=1
//      -> pending stays 4, overflow stays 0, ack_t toggles.
//  T6: assert rst_n mid-stream with pending=2 and evt_count=0xFF, then rerun T2
//      -> all outputs 0 immediately; after release, evt_count=1 (wrap check done separately: 256 toggles -> 0).

Source files
------------

// File: rtl/toggle_event_responder.sv
// Receiver for a toggle-encoded event link: synchronises t_in, turns each level change
// into a buffered event for a valid/ready consumer, and answers each consumed event with an ack toggle.
module toggle_event_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         t_in,
    input  logic                         evt_ready,
    input  logic                         clr_ovf,
    output logic                         pulse_out,
    output logic                         evt_valid,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         ack_t,
    output logic [CNT_W-1:0]             evt_count,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {INIT, IDLE, BUSY, FULL} state_t;

    state_t        state_q, state_d;
    logic [1:0]    init_cnt;
    logic          init_done;
    logic          t_sync, t_prev;
    logic          det, accept, drop;
    logic [PW-1:0] pending_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign t_sync = t_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= t_in;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign t_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // INIT holds off detection until the synchroniser and t_prev carry the real t_in level.
    assign init_done = (init_cnt == 2'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            init_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT && !init_done) init_cnt <= init_cnt + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT)            state_d = init_done ? IDLE : INIT;
        else if (pending_d == '0)       state_d = IDLE;
        else if (pending_d == PW'(DEPTH)) state_d = FULL;
        else                            state_d = BUSY;
    end

    always_comb begin
        det       = (t_sync ^ t_prev) & (state_q != INIT);
        accept    = evt_valid & evt_ready;
        drop      = det & ~accept & (state_q == FULL);
        pending_d = pending;
        if (det && !accept && state_q != FULL) pending_d = pending + PW'(1);
        else if (!det && accept)               pending_d = pending - PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_prev    <= 1'b0;
            pulse_out <= 1'b0;
            pending   <= '0;
            evt_valid <= 1'b0;
            ack_t     <= 1'b0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            t_prev    <= t_sync;
            pulse_out <= det;
            pending   <= pending_d;
            evt_valid <= (pending_d != '0);
            ack_t     <= ack_t ^ accept;
            evt_count <= evt_count + CNT_W'(det);
            // a drop in the same cycle as clr_ovf keeps the flag set
            overflow  <= drop | (overflow & ~clr_ovf);
        end
    end
endmodule

// File: tb/tb_toggle_event_responder.sv
// Directed bench for toggle_event_responder (SYNC_STAGES=2, DEPTH=4, CNT_W=8).
module tb_toggle_event_responder;
    logic       clk = 1'b0;
    logic       rst_n, t_in, evt_ready, clr_ovf;
    logic       pulse_out, evt_valid, ack_t, overflow;
    logic [2:0] pending;
    logic [7:0] evt_count;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int pc0;
    logic exp_ack;

    toggle_event_responder #(.SYNC_STAGES(2), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .t_in(t_in), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .pulse_out(pulse_out), .evt_valid(evt_valid), .pending(pending), .ack_t(ack_t),
        .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pulse_out) pulse_cnt++;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pulse"}, pulse_out, 0);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_pend"},  pending, 0);
        chk({tag, "_ack"},   ack_t, 0);
        chk({tag, "_cnt"},   evt_count, 0);
        chk({tag, "_ovf"},   overflow, 0);
    endtask

    // one toggle observed from a pending=0 start: pulse lands after the third edge only
    task automatic do_t2(input int unsigned exp_cnt);
        t_in = ~t_in;
        tick(); chk("t2_e0_pulse", pulse_out, 0);
        tick(); chk("t2_e1_pulse", pulse_out, 0);
        tick();
        chk("t2_e2_pulse", pulse_out, 1);
        chk("t2_pend", pending, 1);
        chk("t2_valid", evt_valid, 1);
        chk("t2_cnt", evt_count, exp_cnt);
        tick(); chk("t2_e3_pulse", pulse_out, 0);
    endtask

    task automatic tog4();
        t_in = ~t_in;
        ticks(4);
    endtask

    initial begin
        rst_n = 1'b0; t_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0; exp_ack = 1'b0;
        ticks(3);
        chk_zero("rst");

        // T1: t_in high across reset release must not create an event
        pc0 = pulse_cnt;
        rst_n = 1'b1;
        ticks(5);
        chk("t1_pulses", pulse_cnt - pc0, 0);
        chk("t1_pend", pending, 0);
        chk("t1_cnt", evt_count, 0);
        chk("t1_valid", evt_valid, 0);

        // T2
        do_t2(1);

        // drain the single event
        evt_ready = 1'b1; tick(); evt_ready = 1'b0; exp_ack = ~exp_ack;
        chk("drain_pend", pending, 0);
        chk("drain_ack", ack_t, exp_ack);
        chk("drain_valid", evt_valid, 0);

        // T3
        for (int i = 1; i <= 3; i++) begin
            tog4();
            chk("t3_fill_pend", pending, i);
        end
        evt_ready = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick(); exp_ack = ~exp_ack;
            chk("t3_drain_pend", pending, i);
            chk("t3_drain_ack", ack_t, exp_ack);
        end
        chk("t3_valid", evt_valid, 0);
        tick();
        chk("t3_idle_ack", ack_t, exp_ack);
        evt_ready = 1'b0;
        chk("t3_cnt", evt_count, 4);

        // T4: fifth toggle is dropped
        pc0 = pulse_cnt;
        for (int i = 0; i < 5; i++) tog4();
        chk("t4_pend", pending, 4);
        chk("t4_ovf", overflow, 1);
        chk("t4_cnt", evt_count, 9);
        chk("t4_pulses", pulse_cnt - pc0, 5);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("t4_clr_ovf", overflow, 0);
        chk("t4_clr_pend", pending, 4);

        // T5: toggle and accept on the same edge while FULL
        t_in = ~t_in;
        ticks(2);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0; exp_ack = ~exp_ack;
        chk("t5_pulse", pulse_out, 1);
        chk("t5_pend", pending, 4);
        chk("t5_ovf", overflow, 0);
        chk("t5_ack", ack_t, exp_ack);
        chk("t5_cnt", evt_count, 10);

        // drop coinciding with clr_ovf leaves overflow set
        t_in = ~t_in;
        ticks(2);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("prio_ovf", overflow, 1);
        chk("prio_pend", pending, 4);
        chk("prio_cnt", evt_count, 11);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("prio_clr", overflow, 0);

        // T6 setup: fresh start, 253 consumed toggles then 2 held -> pending=2, count=0xFF
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ticks(4);
        evt_ready = 1'b1;
        for (int i = 0; i < 253; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(4);
        evt_ready = 1'b0;
        chk("t6_pre_pend0", pending, 0);
        tog4(); tog4();
        chk("t6_pre_pend", pending, 2);
        chk("t6_pre_cnt", evt_count, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        tick();
        rst_n = 1'b1;
        ticks(4);
        do_t2(1);

        // wrap: 255 more toggles take the counter from 1 through 256 back to 0
        for (int i = 0; i < 255; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(4);
        chk("wrap_cnt", evt_count, 0);
        chk("wrap_ovf", overflow, 1);
        chk("wrap_pend", pending, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
